// File: rtl/cpu_pkg.sv
// Shared core definitions: register-file geometry and the requester encoding
// used by the write-port arbiter.
package cpu_pkg;
  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int NREGS = 1 << AW;

  typedef enum logic {
    REQ_EX = 1'b0,
    REQ_LD = 1'b1
  } req_e;
endpackage

// File: rtl/rf_wb_sched_if.sv
// Issue, producer and RF write-port signals of the write-back scheduler.
// Signal prefixes are from the scheduler's point of view.
interface rf_wb_sched_if #(
  parameter int CNT_W = 16
);
  import cpu_pkg::*;

  logic              i_iss_valid;
  logic [AW-1:0]     i_iss_rs1;
  logic [AW-1:0]     i_iss_rs2;
  logic [AW-1:0]     i_iss_rd;
  logic              i_iss_rs1_en;
  logic              i_iss_rs2_en;
  logic              i_iss_rd_en;
  logic              o_stall;
  logic              i_ex_valid;
  logic [AW-1:0]     i_ex_rd;
  logic [XLEN-1:0]   i_ex_data;
  logic              o_ex_ready;
  logic              i_ld_valid;
  logic [AW-1:0]     i_ld_rd;
  logic [XLEN-1:0]   i_ld_data;
  logic              o_ld_ready;
  logic              o_wr_en;
  logic [AW-1:0]     o_wr_addr;
  logic [XLEN-1:0]   o_wr_data;
  logic [NREGS-1:0]  o_pending;
  logic [CNT_W-1:0]  o_conflict_cnt;
  logic              o_err;

  modport slave (
    input  i_iss_valid, i_iss_rs1, i_iss_rs2, i_iss_rd,
    input  i_iss_rs1_en, i_iss_rs2_en, i_iss_rd_en,
    input  i_ex_valid, i_ex_rd, i_ex_data,
    input  i_ld_valid, i_ld_rd, i_ld_data,
    output o_stall, o_ex_ready, o_ld_ready,
    output o_wr_en, o_wr_addr, o_wr_data,
    output o_pending, o_conflict_cnt, o_err
  );

  modport master (
    output i_iss_valid, i_iss_rs1, i_iss_rs2, i_iss_rd,
    output i_iss_rs1_en, i_iss_rs2_en, i_iss_rd_en,
    output i_ex_valid, i_ex_rd, i_ex_data,
    output i_ld_valid, i_ld_rd, i_ld_data,
    input  o_stall, o_ex_ready, o_ld_ready,
    input  o_wr_en, o_wr_addr, o_wr_data,
    input  o_pending, o_conflict_cnt, o_err
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, RAW/WAW hazard lookup with
// same-cycle write bypass, and a sticky flag for writes nobody was waiting on.
module rf_scoreboard
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_iss_valid,
  input  logic [AW-1:0]    i_iss_rs1,
  input  logic [AW-1:0]    i_iss_rs2,
  input  logic [AW-1:0]    i_iss_rd,
  input  logic             i_iss_rs1_en,
  input  logic             i_iss_rs2_en,
  input  logic             i_iss_rd_en,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  output logic             o_stall,
  output logic [NREGS-1:0] o_pending,
  output logic             o_err
);
  localparam logic [NREGS-1:0] ONE = {{(NREGS-1){1'b0}}, 1'b1};

  logic [NREGS-1:0] r_pending;
  logic             r_err;
  logic [NREGS-1:0] w_set_mask;
  logic [NREGS-1:0] w_clr_mask;
  logic             w_issue;

  // A write landing this cycle reaches the reader through RF bypass.
  function automatic logic hazard(input logic [NREGS-1:0] pend, input logic [AW-1:0] r,
                                  input logic we, input logic [AW-1:0] wa);
    return pend[r] && !(we && (wa == r));
  endfunction

  always_comb begin
    o_stall = !rst && i_iss_valid &&
              ((i_iss_rs1_en && hazard(r_pending, i_iss_rs1, i_wr_en, i_wr_addr)) ||
               (i_iss_rs2_en && hazard(r_pending, i_iss_rs2, i_wr_en, i_wr_addr)) ||
               (i_iss_rd_en  && hazard(r_pending, i_iss_rd,  i_wr_en, i_wr_addr)));
    w_issue    = !rst && i_iss_valid && !o_stall && i_iss_rd_en && (i_iss_rd != '0);
    w_set_mask = w_issue ? (ONE << i_iss_rd) : '0;
    w_clr_mask = i_wr_en ? (ONE << i_wr_addr) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_err     <= 1'b0;
    end else begin
      // Set is applied after clear so a same-cycle reissue keeps the bit.
      r_pending <= ((r_pending & ~w_clr_mask) | w_set_mask) & ~ONE;
      if (i_wr_en && !r_pending[i_wr_addr]) r_err <= 1'b1;
    end
  end

  assign o_pending = r_pending;
  assign o_err     = r_err;
endmodule

// File: rtl/rf_wb_sched.sv
// Register-file write-port scheduler: round-robin arbitration between the EX
// and LD result producers, conflict counter, and the pending-write scoreboard.
module rf_wb_sched
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic         clk,
  input logic         rst,
  rf_wb_sched_if.slave bus
);
  req_e             r_rr_last;
  logic [CNT_W-1:0] r_conflict_cnt;
  logic             w_ex_gnt;
  logic             w_ld_gnt;
  logic             w_gnt;
  logic [AW-1:0]    w_wr_addr;
  logic [XLEN-1:0]  w_wr_data;
  logic             w_wr_en;
  logic             w_stall;
  logic [NREGS-1:0] w_pending;
  logic             w_err;

  always_comb begin
    w_ex_gnt  = !rst && bus.i_ex_valid && (!bus.i_ld_valid || (r_rr_last == REQ_LD));
    w_ld_gnt  = !rst && bus.i_ld_valid && !w_ex_gnt;
    w_gnt     = w_ex_gnt || w_ld_gnt;
    w_wr_addr = w_ex_gnt ? bus.i_ex_rd   : (w_ld_gnt ? bus.i_ld_rd   : '0);
    w_wr_data = w_ex_gnt ? bus.i_ex_data : (w_ld_gnt ? bus.i_ld_data : '0);
    // x0 grants are consumed without touching the write port.
    w_wr_en   = w_gnt && (w_wr_addr != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_last      <= REQ_LD;
      r_conflict_cnt <= '0;
    end else begin
      if (w_ex_gnt)      r_rr_last <= REQ_EX;
      else if (w_ld_gnt) r_rr_last <= REQ_LD;
      if (bus.i_ex_valid && bus.i_ld_valid && (r_conflict_cnt != {CNT_W{1'b1}}))
        r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  rf_scoreboard u_sb (
    .clk          (clk),
    .rst          (rst),
    .i_iss_valid  (bus.i_iss_valid),
    .i_iss_rs1    (bus.i_iss_rs1),
    .i_iss_rs2    (bus.i_iss_rs2),
    .i_iss_rd     (bus.i_iss_rd),
    .i_iss_rs1_en (bus.i_iss_rs1_en),
    .i_iss_rs2_en (bus.i_iss_rs2_en),
    .i_iss_rd_en  (bus.i_iss_rd_en),
    .i_wr_en      (w_wr_en),
    .i_wr_addr    (w_wr_addr),
    .o_stall      (w_stall),
    .o_pending    (w_pending),
    .o_err        (w_err)
  );

  assign bus.o_stall        = w_stall;
  assign bus.o_ex_ready     = w_ex_gnt;
  assign bus.o_ld_ready     = w_ld_gnt;
  assign bus.o_wr_en        = w_wr_en;
  assign bus.o_wr_addr      = w_wr_addr;
  assign bus.o_wr_data      = w_wr_data;
  assign bus.o_pending      = rst ? '0 : w_pending;
  assign bus.o_conflict_cnt = rst ? '0 : r_conflict_cnt;
  assign bus.o_err          = !rst && w_err;
endmodule

// File: tb/tb_rf_wb_sched.sv
// Randomized and directed bench for rf_wb_sched against a behavioural model.
module tb_rf_wb_sched;
  import cpu_pkg::*;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_wb_sched_if #(.CNT_W(CNT_W)) bus ();
  rf_wb_sched #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  bit m_pend [NREGS];
  bit m_last_ld;
  int m_cnt;
  bit m_err;
  bit m_gex, m_gld;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREGS-1:0] pend_vec();
    logic [NREGS-1:0] v;
    for (int i = 0; i < NREGS; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic bit haz(input int r, input bit wen, input int wa);
    return m_pend[r] && !(wen && wa == r);
  endfunction

  task automatic idle();
    bus.i_iss_valid = 0; bus.i_iss_rs1 = 0; bus.i_iss_rs2 = 0; bus.i_iss_rd = 0;
    bus.i_iss_rs1_en = 0; bus.i_iss_rs2_en = 0; bus.i_iss_rd_en = 0;
    bus.i_ex_valid = 0; bus.i_ex_rd = 0; bus.i_ex_data = 0;
    bus.i_ld_valid = 0; bus.i_ld_rd = 0; bus.i_ld_data = 0;
  endtask

  // Inputs are set after a falling edge; this checks, clocks and updates the model.
  task automatic cycle();
    bit gex, gld, wen, stl, issue;
    int wa;
    logic [XLEN-1:0] wd;
    #1;
    gex = 0; gld = 0;
    if (!rst) begin
      if (bus.i_ex_valid && bus.i_ld_valid) begin
        gex = m_last_ld; gld = !m_last_ld;
      end else begin
        gex = bus.i_ex_valid; gld = bus.i_ld_valid;
      end
    end
    wa  = gex ? int'(bus.i_ex_rd) : (gld ? int'(bus.i_ld_rd) : 0);
    wd  = gex ? bus.i_ex_data : (gld ? bus.i_ld_data : '0);
    wen = (gex || gld) && wa != 0;
    stl = !rst && bus.i_iss_valid &&
          ((bus.i_iss_rs1_en && haz(bus.i_iss_rs1, wen, wa)) ||
           (bus.i_iss_rs2_en && haz(bus.i_iss_rs2, wen, wa)) ||
           (bus.i_iss_rd_en  && haz(bus.i_iss_rd,  wen, wa)));
    issue = !rst && bus.i_iss_valid && !stl && bus.i_iss_rd_en && bus.i_iss_rd != 0;
    chk("ex_ready", bus.o_ex_ready, gex);
    chk("ld_ready", bus.o_ld_ready, gld);
    chk("wr_en",    bus.o_wr_en,    wen);
    if (wen) begin
      chk("wr_addr", bus.o_wr_addr, wa);
      chk("wr_data", bus.o_wr_data, wd);
    end
    chk("stall", bus.o_stall, stl);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NREGS; i++) m_pend[i] = 0;
      m_last_ld = 1; m_cnt = 0; m_err = 0;
    end else begin
      if (wen && !m_pend[wa]) m_err = 1;
      if (wen) m_pend[wa] = 0;
      if (issue) m_pend[bus.i_iss_rd] = 1;
      if (gex) m_last_ld = 0;
      if (gld) m_last_ld = 1;
      if (bus.i_ex_valid && bus.i_ld_valid && m_cnt < CNT_MAX) m_cnt++;
    end
    m_gex = gex; m_gld = gld;
    #1;
    chk("pending",  bus.o_pending,      pend_vec());
    chk("conflict", bus.o_conflict_cnt, m_cnt);
    chk("err",      bus.o_err,          m_err);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; idle();
    cycle(); cycle();
    rst = 0;
  endtask

  task automatic issue_rd(input int rd);
    idle();
    bus.i_iss_valid = 1; bus.i_iss_rd = rd[AW-1:0]; bus.i_iss_rd_en = 1;
    cycle();
  endtask

  initial begin
    idle();
    @(negedge clk);
    do_reset();
    chk("rst_pending", bus.o_pending, 0);
    chk("rst_err", bus.o_err, 0);

    // RAW on x5 and its release by an EX write.
    issue_rd(5);
    chk("p5_set", bus.o_pending[5], 1);
    idle(); bus.i_iss_valid = 1; bus.i_iss_rs1 = 5; bus.i_iss_rs1_en = 1;
    #1 chk("raw_stall", bus.o_stall, 1);
    cycle();
    bus.i_ex_valid = 1; bus.i_ex_rd = 5; bus.i_ex_data = 32'hDEADBEEF;
    #1;
    chk("bypass_wen", bus.o_wr_en, 1);
    chk("bypass_wdata", bus.o_wr_data, 32'hDEADBEEF);
    chk("bypass_nostall", bus.o_stall, 0);
    cycle();
    chk("p5_clr", bus.o_pending[5], 0);

    // x0 grant: consumed, no write.
    idle(); bus.i_ex_valid = 1; bus.i_ex_rd = 0; bus.i_ex_data = 32'h1234;
    #1 chk("x0_ready", bus.o_ex_ready, 1);
    chk("x0_wen", bus.o_wr_en, 0);
    cycle();
    chk("x0_err", bus.o_err, 0);

    // Same-cycle write and reissue of x7: set wins.
    issue_rd(7);
    idle(); bus.i_iss_valid = 1; bus.i_iss_rd = 7; bus.i_iss_rd_en = 1;
    bus.i_ld_valid = 1; bus.i_ld_rd = 7; bus.i_ld_data = 32'h77;
    #1 chk("x7_nostall", bus.o_stall, 0);
    cycle();
    chk("x7_pending", bus.o_pending[7], 1);

    // Conflict right after reset: EX then LD.
    do_reset();
    idle();
    bus.i_ex_valid = 1; bus.i_ex_rd = 3; bus.i_ex_data = 32'h11;
    bus.i_ld_valid = 1; bus.i_ld_rd = 4; bus.i_ld_data = 32'h22;
    #1 chk("cf0_ex", bus.o_ex_ready, 1);
    cycle();
    bus.i_ex_valid = 0;
    #1 chk("cf1_ld", bus.o_ld_ready, 1);
    cycle();
    idle(); cycle();
    chk("cf_cnt", bus.o_conflict_cnt, 1);

    // Write to a register nobody is waiting for.
    do_reset();
    idle(); bus.i_ex_valid = 1; bus.i_ex_rd = 9; bus.i_ex_data = 32'h99;
    cycle();
    idle(); cycle(); cycle();
    chk("err_sticky", bus.o_err, 1);

    // Continuous contention alternates grants.
    do_reset();
    idle();
    bus.i_ex_valid = 1; bus.i_ld_valid = 1;
    for (int k = 0; k < 8; k++) begin
      if (m_gex || k == 0) bus.i_ex_rd = AW'($urandom_range(1, NREGS - 1));
      if (m_gld || k == 0) bus.i_ld_rd = AW'($urandom_range(1, NREGS - 1));
      #1 chk("alt_ex", bus.o_ex_ready, (k % 2) == 0);
      chk("alt_ld", bus.o_ld_ready, (k % 2) == 1);
      cycle();
    end

    // Reset with pending writes and both producers active.
    do_reset();
    for (int r = 4; r < 8; r++) issue_rd(r);
    chk("pend_f0", bus.o_pending, 32'h0000_00F0);
    rst = 1;
    bus.i_ex_valid = 1; bus.i_ex_rd = 4; bus.i_ld_valid = 1; bus.i_ld_rd = 5;
    cycle();
    chk("rst_mid_pend", bus.o_pending, 0);
    chk("rst_mid_cnt", bus.o_conflict_cnt, 0);
    rst = 0;
    bus.i_ex_rd = 0; bus.i_ld_rd = 0;
    #1 chk("post_rst_ex", bus.o_ex_ready, 1);
    cycle();

    // Counter saturation with both producers permanently busy on x0.
    for (int k = 0; k < CNT_MAX + 4; k++) cycle();
    chk("cnt_sat", bus.o_conflict_cnt, CNT_MAX);

    // Random traffic with producers that hold requests until consumed.
    do_reset();
    idle();
    for (int k = 0; k < 3000; k++) begin
      bus.i_iss_valid  = $urandom_range(0, 1);
      bus.i_iss_rs1    = AW'($urandom_range(0, 7));
      bus.i_iss_rs2    = AW'($urandom_range(0, 7));
      bus.i_iss_rd     = AW'($urandom_range(0, 7));
      bus.i_iss_rs1_en = $urandom_range(0, 1);
      bus.i_iss_rs2_en = $urandom_range(0, 1);
      bus.i_iss_rd_en  = $urandom_range(0, 1);
      if (rst) begin
        bus.i_ex_valid = 0; bus.i_ld_valid = 0;
      end else begin
        if (m_gex || !bus.i_ex_valid) begin
          bus.i_ex_valid = $urandom_range(0, 1);
          bus.i_ex_rd = AW'($urandom_range(0, 7)); bus.i_ex_data = $urandom;
        end
        if (m_gld || !bus.i_ld_valid) begin
          bus.i_ld_valid = $urandom_range(0, 1);
          bus.i_ld_rd = AW'($urandom_range(0, 7)); bus.i_ld_data = $urandom;
        end
      end
      rst = ($urandom_range(0, 149) == 0);
      cycle();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
